reg4x4_write_ctrl: RTL and testbench

Command-driven write sequencer that sits directly upstream of the 4x4 nibble register file. It accepts one command per valid/ready handshake and expands it into one or more single-cycle writes on the register file's write interface (ce, we, add, dIn). It supports single-nibble writes, 4-nibble burst writes and a clear-all operation, and reports completion with a one-cycle done pulse.

---
 rtl/reg4x4_write_ctrl_if.sv | 26 ++
 rtl/reg4x4_write_ctrl.sv | 168 ++++++++++++++++
 tb/tb_reg4x4_write_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg4x4_write_ctrl_if.sv
// Command handshake plus register-file write bus between a command source and
// the write sequencer; master issues commands, slave drives the write bus.
interface reg4x4_write_ctrl_if;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdMode;
    logic [1:0]  cmdAdd;
    logic [15:0] cmdData;
    logic        ce;
    logic        we;
    logic [1:0]  add;
    logic [3:0]  dIn;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output cmdValid, cmdMode, cmdAdd, cmdData,
        input  cmdReady, ce, we, add, dIn, busy, done, err
    );

    modport slave (
        input  cmdValid, cmdMode, cmdAdd, cmdData,
        output cmdReady, ce, we, add, dIn, busy, done, err
    );
endinterface

// File: rtl/reg4x4_write_ctrl.sv
// Write sequencer for the 4x4 nibble register file: expands single, burst and
// clear commands into single-cycle writes, with optional idle gaps between writes.
module reg4x4_write_ctrl #(
    parameter int WR_GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    reg4x4_write_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_RSVD   = 2'b11;
    localparam logic [2:0] GAP_LOAD    = (WR_GAP > 0) ? 3'(WR_GAP - 1) : 3'd0;

    state_t      r_state, w_state_next;
    logic [1:0]  r_mode, w_mode_next;
    logic [1:0]  r_base, w_base_next;
    logic [15:0] r_data, w_data_next;
    logic [1:0]  r_wcnt, w_wcnt_next;
    logic [2:0]  r_gcnt, w_gcnt_next;
    logic        r_ce, w_ce_next;
    logic        r_we, w_we_next;
    logic [1:0]  r_add, w_add_next;
    logic [3:0]  r_din, w_din_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_err, w_err_next;
    logic        r_ready, w_ready_next;

    logic        w_accept;
    logic        w_last;
    logic [1:0]  w_wnext;

    // Address/data of write k; anything that is not single or burst is a clear.
    function automatic logic [5:0] write_word(input logic [1:0] mode, input logic [1:0] base,
                                              input logic [15:0] data, input logic [1:0] k);
        logic [5:0] w;
        case (mode)
            MODE_SINGLE: w = {base, data[3:0]};
            MODE_BURST:  w = {base + k, data[{k, 2'b00} +: 4]};
            default:     w = {k, 4'h0};
        endcase
        return w;
    endfunction

    assign w_accept = (r_state == S_IDLE) && r_ready && bus.cmdValid;
    assign w_last   = (r_mode == MODE_SINGLE) || (r_wcnt == 2'd3);
    assign w_wnext  = r_wcnt + 2'd1;

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_base_next  = r_base;
        w_data_next  = r_data;
        w_wcnt_next  = r_wcnt;
        w_gcnt_next  = r_gcnt;
        w_ce_next    = 1'b0;
        w_we_next    = 1'b0;
        w_add_next   = r_add;
        w_din_next   = r_din;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_ready_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_next = 1'b1;
                w_busy_next  = 1'b0;
                if (w_accept) begin
                    w_ready_next = 1'b0;
                    w_busy_next  = 1'b1;
                    w_mode_next  = bus.cmdMode;
                    w_base_next  = bus.cmdAdd;
                    w_data_next  = bus.cmdData;
                    w_wcnt_next  = 2'd0;
                    if (bus.cmdMode == MODE_RSVD) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_err_next   = 1'b1;
                    end else begin
                        // First write goes out straight from the command inputs.
                        w_state_next = S_WRITE;
                        w_ce_next    = 1'b1;
                        w_we_next    = 1'b1;
                        {w_add_next, w_din_next} = write_word(bus.cmdMode, bus.cmdAdd, bus.cmdData, 2'd0);
                    end
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end else if (WR_GAP == 0) begin
                    w_state_next = S_WRITE;
                    w_wcnt_next  = w_wnext;
                    w_ce_next    = 1'b1;
                    w_we_next    = 1'b1;
                    {w_add_next, w_din_next} = write_word(r_mode, r_base, r_data, w_wnext);
                end else begin
                    w_state_next = S_GAP;
                    w_gcnt_next  = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (r_gcnt == 3'd0) begin
                    w_state_next = S_WRITE;
                    w_wcnt_next  = w_wnext;
                    w_ce_next    = 1'b1;
                    w_we_next    = 1'b1;
                    {w_add_next, w_din_next} = write_word(r_mode, r_base, r_data, w_wnext);
                end else begin
                    w_gcnt_next = r_gcnt - 3'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_ready_next = 1'b1;
                w_busy_next  = 1'b0;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_base  <= 2'd0;
            r_data  <= 16'd0;
            r_wcnt  <= 2'd0;
            r_gcnt  <= 3'd0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_add   <= 2'd0;
            r_din   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            r_base  <= w_base_next;
            r_data  <= w_data_next;
            r_wcnt  <= w_wcnt_next;
            r_gcnt  <= w_gcnt_next;
            r_ce    <= w_ce_next;
            r_we    <= w_we_next;
            r_add   <= w_add_next;
            r_din   <= w_din_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_ready <= w_ready_next;
        end
    end

    assign bus.cmdReady = r_ready;
    assign bus.ce       = r_ce;
    assign bus.we       = r_we;
    assign bus.add      = r_add;
    assign bus.dIn      = r_din;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_reg4x4_write_ctrl.sv
// Scoreboard bench: two sequencers (WR_GAP=0 and WR_GAP=2) driven with directed
// commands; expected writes/done pulses are queued and matched by a monitor.
module tb_reg4x4_write_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        bit         kind;   // 0 write, 1 done
        logic [1:0] add;
        logic [3:0] din;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    reg4x4_write_ctrl_if bus_g0 ();
    reg4x4_write_ctrl_if bus_g2 ();

    reg4x4_write_ctrl #(.WR_GAP(0)) u_g0 (.clk(clk), .rst(rst), .bus(bus_g0));
    reg4x4_write_ctrl #(.WR_GAP(2)) u_g2 (.clk(clk), .rst(rst), .bus(bus_g2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] outs(input int d);
        if (d == 0)
            return {bus_g0.cmdReady, bus_g0.ce, bus_g0.we, bus_g0.add, bus_g0.dIn,
                    bus_g0.busy, bus_g0.done, bus_g0.err};
        return {bus_g2.cmdReady, bus_g2.ce, bus_g2.we, bus_g2.add, bus_g2.dIn,
                bus_g2.busy, bus_g2.done, bus_g2.err};
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus_g0.cmdReady : bus_g2.cmdReady;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, need %h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic set_cmd(input int d, input logic v, input logic [1:0] m,
                           input logic [1:0] a, input logic [15:0] dat);
        if (d == 0) begin
            bus_g0.cmdValid = v; bus_g0.cmdMode = m; bus_g0.cmdAdd = a; bus_g0.cmdData = dat;
        end else begin
            bus_g2.cmdValid = v; bus_g2.cmdMode = m; bus_g2.cmdAdd = a; bus_g2.cmdData = dat;
        end
    endtask

    task automatic push(input int d, input bit kind, input logic [1:0] a,
                        input logic [3:0] din, input bit err, input int c);
        exp_t e;
        e.kind = kind; e.add = a; e.din = din; e.err = err; e.cyc = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Presents a command at a negedge where cmdReady=1; acc is the accepting edge.
    task automatic issue(input int d, input logic [1:0] m, input logic [1:0] a,
                         input logic [15:0] dat, output int acc);
        int n = 0;
        @(negedge clk);
        while (!rdy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout g%0d: cmdReady=0 after 100 cycles, need 1", d * 2);
        end
        set_cmd(d, 1'b1, m, a, dat);
        acc = cyc + 1;
        $display("cmd g%0d mode=%0d add=%0d data=%h accept_edge=%0d", d * 2, m, a, dat, acc);
    endtask

    task automatic drop(input int d);
        @(posedge clk);
        #1;
        if (d == 0) bus_g0.cmdValid = 1'b0;
        else        bus_g2.cmdValid = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        @(negedge clk);
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    always @(negedge clk) begin : monitor
        logic       m_ce, m_we, m_done, m_err;
        logic [1:0] m_add;
        logic [3:0] m_din;
        exp_t       e;
        bit         have, ok;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                m_ce = bus_g0.ce; m_we = bus_g0.we; m_done = bus_g0.done; m_err = bus_g0.err;
                m_add = bus_g0.add; m_din = bus_g0.dIn;
                have = (q0.size() > 0);
            end else begin
                m_ce = bus_g2.ce; m_we = bus_g2.we; m_done = bus_g2.done; m_err = bus_g2.err;
                m_add = bus_g2.add; m_din = bus_g2.dIn;
                have = (q1.size() > 0);
            end
            if (m_ce || m_done) begin
                total++;
                if (!have) begin
                    bad++;
                    $display("FAIL unexpected_event g%0d: got ce=%0b done=%0b add=%0d dIn=%h at cyc=%0d, need no activity",
                             d * 2, m_ce, m_done, m_add, m_din, cyc);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    if (e.kind == 1'b0)
                        ok = m_ce && m_we && !m_done && (m_add == e.add) && (m_din == e.din) && (cyc == e.cyc);
                    else
                        ok = m_done && !m_ce && (m_err == e.err) && (cyc == e.cyc);
                    if (!ok) begin
                        bad++;
                        $display("FAIL %s g%0d: got ce=%0b we=%0b add=%0d dIn=%h done=%0b err=%0b cyc=%0d, need add=%0d dIn=%h err=%0b cyc=%0d",
                                 e.kind ? "done" : "write", d * 2, m_ce, m_we, m_add, m_din,
                                 m_done, m_err, cyc, e.add, e.din, e.err, e.cyc);
                    end else begin
                        $display("g%0d %s add=%0d dIn=%h err=%0b cyc=%0d ok", d * 2,
                                 e.kind ? "done" : "write", m_add, m_din, m_err, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        set_cmd(0, 1'b0, 2'd0, 2'd0, 16'h0000);
        set_cmd(1, 1'b0, 2'd0, 2'd0, 16'h0000);

        // Reset state and cmdReady rising one edge after release.
        #1;
        check("reset_outs_g0", 32'(outs(0)), 32'h0);
        check("reset_outs_g2", 32'(outs(1)), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_at_release", {30'd0, rdy(0), rdy(1)}, 32'h0);
        @(negedge clk);
        check("ready_after_release", {30'd0, rdy(0), rdy(1)}, 32'h3);
        check("idle_no_ce", {30'd0, bus_g0.ce, bus_g2.ce}, 32'h0);

        // Single write with ready timing.
        issue(0, 2'b00, 2'd3, 16'h000A, acc);
        push(0, 1'b0, 2'd3, 4'hA, 1'b0, acc);
        push(0, 1'b1, 2'd0, 4'h0, 1'b0, acc + 1);
        drop(0);
        wait_until(acc + 1);
        check("single_ready_in_done", 32'(rdy(0)), 32'h0);
        wait_until(acc + 2);
        check("single_ready_back", 32'(rdy(0)), 32'h1);

        // Burst with address wrap; valid held high and inputs changed mid-burst.
        issue(0, 2'b01, 2'd2, 16'h4321, acc);
        push(0, 1'b0, 2'd2, 4'h1, 1'b0, acc);
        push(0, 1'b0, 2'd3, 4'h2, 1'b0, acc + 1);
        push(0, 1'b0, 2'd0, 4'h3, 1'b0, acc + 2);
        push(0, 1'b0, 2'd1, 4'h4, 1'b0, acc + 3);
        push(0, 1'b1, 2'd0, 4'h0, 1'b0, acc + 4);
        wait_until(acc);
        set_cmd(0, 1'b1, 2'b00, 2'd0, 16'hFFF5);
        push(0, 1'b0, 2'd0, 4'h5, 1'b0, acc + 6);
        push(0, 1'b1, 2'd0, 4'h0, 1'b0, acc + 7);
        wait_until(acc + 4);
        check("burst_ready_in_done", 32'(rdy(0)), 32'h0);
        wait_until(acc + 5);
        check("burst_ready_back", 32'(rdy(0)), 32'h1);
        wait_until(acc + 6);
        set_cmd(0, 1'b0, 2'b00, 2'd0, 16'h0000);
        wait_until(acc + 8);
        check("second_ready_back", 32'(rdy(0)), 32'h1);

        // Clear with WR_GAP=2; busy must stay high until the done cycle ends.
        issue(1, 2'b10, 2'd3, 16'hFFFF, acc);
        push(1, 1'b0, 2'd0, 4'h0, 1'b0, acc);
        push(1, 1'b0, 2'd1, 4'h0, 1'b0, acc + 3);
        push(1, 1'b0, 2'd2, 4'h0, 1'b0, acc + 6);
        push(1, 1'b0, 2'd3, 4'h0, 1'b0, acc + 9);
        push(1, 1'b1, 2'd0, 4'h0, 1'b0, acc + 10);
        drop(1);
        for (int k = 0; k <= 10; k++) begin
            wait_until(acc + k);
            check($sformatf("clear_busy_%0d", k), 32'(bus_g2.busy), 32'h1);
        end
        wait_until(acc + 11);
        check("clear_busy_low", 32'(bus_g2.busy), 32'h0);
        check("clear_ready_back", 32'(rdy(1)), 32'h1);

        // Reserved mode: no write, done and err together.
        issue(0, 2'b11, 2'd1, 16'h1234, acc);
        push(0, 1'b1, 2'd0, 4'h0, 1'b1, acc);
        drop(0);
        wait_until(acc + 1);
        check("rsvd_ready_back", 32'(rdy(0)), 32'h1);

        // Burst with gap and wrap on WR_GAP=2.
        issue(1, 2'b01, 2'd1, 16'hBA98, acc);
        push(1, 1'b0, 2'd1, 4'h8, 1'b0, acc);
        push(1, 1'b0, 2'd2, 4'h9, 1'b0, acc + 3);
        push(1, 1'b0, 2'd3, 4'hA, 1'b0, acc + 6);
        push(1, 1'b0, 2'd0, 4'hB, 1'b0, acc + 9);
        push(1, 1'b1, 2'd0, 4'h0, 1'b0, acc + 10);
        drop(1);
        wait_until(acc + 12);

        // Reset after the second write of a burst: the rest is abandoned.
        issue(0, 2'b01, 2'd0, 16'h7654, acc);
        push(0, 1'b0, 2'd0, 4'h4, 1'b0, acc);
        push(0, 1'b0, 2'd1, 4'h5, 1'b0, acc + 1);
        drop(0);
        wait_until(acc + 1);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_outs_g0", 32'(outs(0)), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_ready_back", 32'(rdy(0)), 32'h1);
        repeat (5) @(negedge clk);
        issue(0, 2'b00, 2'd1, 16'h0003, acc);
        push(0, 1'b0, 2'd1, 4'h3, 1'b0, acc);
        push(0, 1'b1, 2'd0, 4'h0, 1'b0, acc + 1);
        drop(0);
        wait_until(acc + 4);

        check("pending_g0", 32'(q0.size()), 32'h0);
        check("pending_g2", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
